// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Optional feature: define MD_DIV0_FLAG_EN to add the registered div0 pulse output.
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
`ifdef MD_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;     // product, or {remainder, quotient}
  logic [WIDTH-1:0]   opb;     // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0]   a_raw;   // untouched dividend for the divide-by-zero result
  logic               is_div;
  logic               neg_q;   // negate product / quotient
  logic               neg_r;   // negate remainder

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  logic               op_arith;
  logic               op_signed;
  logic               op_mult;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op_arith  = (OP >= 4'd1) && (OP <= 4'd4);
    op_signed = (OP == 4'd1) || (OP == 4'd3);
    op_mult   = (OP == 4'd1) || (OP == 4'd2);
    a_mag     = mag(A, op_signed);
    b_mag     = mag(B, op_signed);

    // Multiply step: conditional add into the upper half, then shift right with the carry.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

    // Restoring divide step: remainder gains one bit, subtract if it covers the divisor.
    rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opb};
    rem_sub   = rem_ge ? (rem_sh - {1'b0, opb}) : rem_sh;

    acc_step  = is_div ? {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], rem_ge}
                       : {mul_sum, acc[WIDTH-1:1]};

    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (opb == '0) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      HI     <= '0;
      LO     <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MD_DIV0_FLAG_EN
      div0   <= 1'b0;
`endif
    end else begin
`ifdef MD_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_arith) begin
              state  <= S_RUN;
              busy   <= 1'b1;
              cnt    <= CW'(WIDTH);
              is_div <= !op_mult;
              opb    <= op_mult ? a_mag : b_mag;
              acc    <= {{WIDTH{1'b0}}, (op_mult ? b_mag : a_mag)};
              a_raw  <= A;
              neg_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_r  <= op_signed && !op_mult && A[WIDTH-1];
            end else if (OP == 4'd5) begin
              HI <= A;
            end else if (OP == 4'd6) begin
              LO <= A;
            end
          end
          S_RUN: begin
            acc <= acc_step;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
          S_FIX: begin
            HI    <= res_hi;
            LO    <= res_lo;
            busy  <= 1'b0;
            state <= S_IDLE;
`ifdef MD_DIV0_FLAG_EN
            div0  <= is_div && (opb == '0);
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Randomised self-checking bench for md_iter_unit against a 64-bit arithmetic model.
module tb_md_iter_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   OP = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         flush = 1'b0;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         busy;
`ifdef MD_DIV0_FLAG_EN
  logic         div0;
`endif

  md_iter_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .flush (flush),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy)
`ifdef MD_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  // Reference results straight from the arithmetic definition of each opcode.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      4'd1: r = 64'(sa * sb);
      4'd2: r = {32'b0, a} * {32'b0, b};
      4'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin r[31:0] = 32'(sa / sb); r[63:32] = 32'(sa % sb); end
      4'd4: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Caller is at a negedge; issues op, presents junk_op during busy, checks latency and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] junk_op);
    logic [63:0] e;
    int k;
    e  = model(op, a, b);
    OP = op; A = a; B = b;
    @(negedge clk);
    OP = 4'd0; A = $urandom; B = $urandom;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept op=%0d got %b want 1", op, busy);
    end
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      OP = junk_op; A = $urandom;
      @(negedge clk);
      k++;
    end
    OP = 4'd0;
    vectors++;
    if (k !== W + 1) begin
      miscompares++;
      $display("FAIL latency op=%0d got %0d want %0d", op, k, W + 1);
    end
    vectors++;
    if (HI !== e[63:32] || LO !== e[31:0]) begin
      miscompares++;
      $display("FAIL result op=%0d a=%h b=%h got HI=%h LO=%h want HI=%h LO=%h",
               op, a, b, HI, LO, e[63:32], e[31:0]);
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
`ifdef MD_DIV0_FLAG_EN
    vectors++;
    if (div0 !== (op >= 4'd3 && b == 0)) begin
      miscompares++;
      $display("FAIL div0_pulse op=%0d b=%h got %b want %b", op, b, div0, (op >= 4'd3 && b == 0));
    end
    @(negedge clk);
    vectors++;
    if (div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL div0_width got %b want 0", div0);
    end
`endif
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (HI !== '0 || LO !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got HI=%h LO=%h busy=%b want 0/0/0", HI, LO, busy);
    end
    @(negedge clk); reset = 1'b1;
    OP = 4'd5; A = 32'h1111_2222; @(negedge clk);
    OP = 4'd6; A = 32'h3333_4444; @(negedge clk);
    OP = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3; @(negedge clk);
    OP = 4'd0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (HI !== '0 || LO !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run got HI=%h LO=%h busy=%b want 0/0/0", HI, LO, busy);
    end
    @(negedge clk); reset = 1'b1;
    repeat (W + 3) @(negedge clk);
    vectors++;
    if (HI !== '0 || LO !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_after got HI=%h LO=%h busy=%b want 0/0/0", HI, LO, busy);
    end
`ifdef MD_DIV0_FLAG_EN
    vectors++;
    if (div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div0 got %b want 0", div0);
    end
`endif
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_directed();
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 4'd0);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 4'd0);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0);
    run_op(4'd4, 32'h1234_5678, 32'd0, 4'd0);
    run_op(4'd3, 32'h8765_4321, 32'd0, 4'd0);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 4'd0);
  endtask

  task automatic test_mthi_mtlo();
    OP = 4'd5; A = 32'hAAAA_5555; @(negedge clk);
    vectors++;
    if (HI !== 32'hAAAA_5555 || LO !== exp_lo || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi got HI=%h LO=%h busy=%b want HI=aaaa5555 LO=%h busy=0", HI, LO, busy, exp_lo);
    end
    OP = 4'd6; A = 32'h0F0F_0F0F; @(negedge clk);
    vectors++;
    if (HI !== 32'hAAAA_5555 || LO !== 32'h0F0F_0F0F || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo got HI=%h LO=%h busy=%b want HI=aaaa5555 LO=0f0f0f0f busy=0", HI, LO, busy);
    end
    exp_hi = 32'hAAAA_5555;
    exp_lo = 32'h0F0F_0F0F;
    OP = 4'd5; A = 32'hDEAD_BEEF; flush = 1'b1; @(negedge clk);
    flush = 1'b0; OP = 4'd0;
    vectors++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      miscompares++;
      $display("FAIL flush_idle_mthi got HI=%h LO=%h want HI=%h LO=%h", HI, LO, exp_hi, exp_lo);
    end
    // mtlo presented while busy must be ignored
    run_op(4'd2, 32'h0000_1234, 32'h0000_5678, 4'd6);
  endtask

  task automatic test_flush();
    OP = 4'd2; A = $urandom; B = $urandom; @(negedge clk);
    OP = 4'd0;
    repeat (9) @(negedge clk);
    flush = 1'b1; @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      miscompares++;
      $display("FAIL flush_run got busy=%b HI=%h LO=%h want 0 HI=%h LO=%h", busy, HI, LO, exp_hi, exp_lo);
    end
    run_op(4'd4, 32'd100, 32'd7, 4'd0);
    // flush landing on the FIX edge of a divide by zero
    OP = 4'd3; A = 32'h5555_AAAA; B = 32'd0; @(negedge clk);
    OP = 4'd0;
    repeat (W) @(negedge clk);
    flush = 1'b1; @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      miscompares++;
      $display("FAIL flush_fix got busy=%b HI=%h LO=%h want 0 HI=%h LO=%h", busy, HI, LO, exp_hi, exp_lo);
    end
`ifdef MD_DIV0_FLAG_EN
    vectors++;
    if (div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_div0 got %b want 0", div0);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, 4'($urandom_range(0, 8)));
    end
  endtask

  task automatic test_back_to_back();
    // run_op returns on the negedge where busy first reads 0, so each op issues immediately
    run_op(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd0);
    run_op(4'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 4'd0);
    run_op(4'd4, 32'hFFFF_FFFF, 32'h0000_0010, 4'd0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_flush();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised iterative multiply/divide unit for the pipelined MIPS core. It replaces the fixed-latency HI/LO unit with a true radix-2 shift-add multiplier and restoring divider of configurable width. It sits beside the EX-stage ALU and drives `busy` to the hazard unit, which stalls any later HI/LO instruction. It adds a `flush` input so an in-flight operation can be killed on exception or interrupt.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `OP`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 none.
- `A`  in  WIDTH  rs operand / dividend / multiplicand / mthi-mtlo data.
- `B`  in  WIDTH  rt operand / divisor / multiplier.
- `flush`  in  1  synchronous kill of the current and presented operation.
- `HI`  out  WIDTH  HI register, registered.
- `LO`  out  WIDTH  LO register, registered.
- `busy`  out  1  high while an arithmetic operation is in flight.
- `div0`  out  1  present only with `MD_DIV0_FLAG_EN`; see Configuration.

## Operation
- States: IDLE, RUN, FIX. Reset: state IDLE, `HI`=0, `LO`=0, `busy`=0, internal counter and accumulators 0.
- IDLE:
  - `OP` in 1–4 with `flush`=0 is accepted. The block latches |A| and |B| (signed ops) or A and B (unsigned), plus the result signs, and goes to RUN with counter = WIDTH.
  - `OP`=5 writes HI←A; `OP`=6 writes LO←A. Both take effect at the same edge and the block stays in IDLE.
  - `OP` 7/8 are no-ops; HI and LO are read combinationally by the core.
- RUN, one bit per cycle, counter decrements; at counter 1 → FIX.
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half of the 2·WIDTH product; then shift the product right 1.
  - Divide (restoring): shift {rem,quo} left 1; if rem ≥ divisor, subtract and set quo LSB.
- FIX, one cycle:
  - Negate product if the signs differ (mult).
  - Negate quotient if sign(A)≠sign(B), and negate remainder if A<0 (div).
  - Write {HI,LO}: product high/low, or HI=remainder, LO=quotient. Return to IDLE.
- Signed division overflow (most-negative ÷ −1): LO=most-negative, HI=0. This falls out of the magnitude path with no special case.
- Divide by zero (div or divu, B=0): LO=all ones, HI=A (raw operand), regardless of signedness.
- `OP` is ignored in RUN and FIX. The hazard unit guarantees no HI/LO instruction issues while `busy`=1.
- `flush`=1 at an edge in RUN or FIX → IDLE, `busy`=0, HI/LO unchanged. In IDLE, `flush`=1 drops the presented `OP`, including 5/6.
- Reset asserted mid-operation immediately forces the reset state.

## Timing
- Accept at edge E0 → `busy`=1 after E0.
- RUN occupies WIDTH cycles; FIX writes HI/LO at edge E0+WIDTH+1. `busy` falls at that same edge.
- Total latency WIDTH+1 cycles for all four arithmetic ops; 33 for WIDTH=32.
- Back-to-back: a new `OP` may be accepted in the cycle after `busy` falls. No same-edge chaining.
- mthi/mtlo: latency 1 edge; `busy` stays 0.
- `flush` at edge E_f in RUN/FIX: `busy`=0 after E_f.

## Configuration
- `MD_DIV0_FLAG_EN` defined:
  - `div0` is a registered output, reset 0.
  - It goes to 1 for exactly one cycle, at the FIX-edge of a div/divu with B=0; otherwise it is 0.
  - A flushed division never raises it.
- Undefined: the `div0` port and its logic are absent; divide-by-zero results are unchanged.

## Test plan
- Reset low mid-RUN of a mult → HI=0, LO=0, busy=0 immediately. After release, an `OP`=0 idle cycle leaves all outputs 0.
- mult A=0xFFFFFFFE (−2), B=3 → busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678. With `MD_DIV0_FLAG_EN`, `div0` high for one cycle at completion.
- mthi A=0xAAAA5555 followed the next cycle by mtlo A=0x0F0F0F0F → HI/LO updated 1 edge after each, busy never asserted. `OP`=6 issued while busy → LO unchanged.
- multu started, `flush` pulsed at cycle 10 → busy=0 next edge, HI/LO unchanged. A new divu A=100, B=7 accepted on the next cycle → LO=14, HI=2 after 33 cycles.
